// File: rtl/sq_sum_feeder_if.sv
// Job request/result bus of the sum-of-squares feeder plus its launch handshake
// toward the downstream square-root unit.
interface sq_sum_feeder_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
);
  logic [IN_W-1:0]  a_bi;
  logic [IN_W-1:0]  b_bi;
  logic             start_i;
  logic             busy_o;
  logic [OUT_W-1:0] y_bo;
  logic             sat_o;
  logic             sqrt_busy_i;
  logic             sqrt_start_o;
  logic [OUT_W-1:0] sqrt_x_bo;

  modport master (
    output a_bi, b_bi, start_i, sqrt_busy_i,
    input  busy_o, y_bo, sat_o, sqrt_start_o, sqrt_x_bo
  );

  modport slave (
    input  a_bi, b_bi, start_i, sqrt_busy_i,
    output busy_o, y_bo, sat_o, sqrt_start_o, sqrt_x_bo
  );
endinterface

// File: rtl/sq_sum_feeder.sv
// Computes a*a + b*b with a shift-add multiplier, saturates to OUT_W bits and
// launches the downstream square-root unit once it reports idle.
module sq_sum_feeder #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sq_sum_feeder_if.slave  bus
);

  localparam int ACC_W = 2 * IN_W + 1;
  localparam int MC_W  = 2 * IN_W;
  localparam int CNT_W = $clog2(IN_W) + 1;
  localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_W - 1);
  localparam logic [CMP_W-1:0] Y_MAX    = CMP_W'({OUT_W{1'b1}});

  typedef enum logic [2:0] {
    IDLE,
    MUL_A,
    MUL_B,
    SUM,
    WAIT_DS,
    ISSUE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ACC_W-1:0]  acc;
  logic [MC_W-1:0]   mcand;
  logic [IN_W-1:0]   mplier;
  logic [IN_W-1:0]   b_reg;
  logic [CNT_W-1:0]  cnt;
  logic [OUT_W-1:0]  y_reg;
  logic              sat_reg;
  logic              sqrt_start_reg;
  logic [OUT_W-1:0]  sqrt_x_reg;
  logic [CMP_W-1:0]  acc_ext;
  logic              sat_now;
  logic [OUT_W-1:0]  y_now;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start_i)      next_state = MUL_A;
      MUL_A:   if (cnt == LAST_BIT)  next_state = MUL_B;
      MUL_B:   if (cnt == LAST_BIT)  next_state = SUM;
      SUM:                           next_state = WAIT_DS;
      WAIT_DS: if (!bus.sqrt_busy_i) next_state = ISSUE;
      ISSUE:                         next_state = IDLE;
      default:                       next_state = IDLE;
    endcase
  end

  // Widen to whichever is larger so the saturation test also holds when the
  // accumulator is narrower than the output (saturation then never fires).
  always_comb begin
    acc_ext = CMP_W'(acc);
    sat_now = (acc_ext > Y_MAX);
    y_now   = sat_now ? {OUT_W{1'b1}} : acc_ext[OUT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      b_reg          <= '0;
      cnt            <= '0;
      y_reg          <= '0;
      sat_reg        <= 1'b0;
      sqrt_start_reg <= 1'b0;
      sqrt_x_reg     <= '0;
    end else begin
      sqrt_start_reg <= (state == WAIT_DS) && !bus.sqrt_busy_i;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            b_reg  <= bus.b_bi;
            mcand  <= MC_W'(bus.a_bi);
            mplier <= bus.a_bi;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL_A, MUL_B: begin
          if (mplier[0]) begin
            acc <= acc + ACC_W'(mcand);
          end
          // The last step of a*a reloads both shift registers with b so b*b
          // accumulates onto the same sum without an extra cycle.
          if (cnt == LAST_BIT) begin
            cnt <= '0;
            if (state == MUL_A) begin
              mcand  <= MC_W'(b_reg);
              mplier <= b_reg;
            end
          end else begin
            cnt    <= cnt + 1'b1;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        SUM: begin
          y_reg      <= y_now;
          sat_reg    <= sat_now;
          sqrt_x_reg <= y_now;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy_o       = (state != IDLE);
  assign bus.y_bo         = y_reg;
  assign bus.sat_o        = sat_reg;
  assign bus.sqrt_start_o = sqrt_start_reg;
  assign bus.sqrt_x_bo    = sqrt_x_reg;

endmodule

// File: tb/tb_sq_sum_feeder.sv
// Self-checking bench for sq_sum_feeder: reference model works on plain integer
// arithmetic (a*a + b*b clipped to the output range) and fixed job latency.
module tb_sq_sum_feeder;

  localparam int IN_W     = 4;
  localparam int OUT_W    = 8;
  localparam int Y_MAX    = (1 << OUT_W) - 1;
  localparam int PULSE_AT = 2 * IN_W + 2;

  logic clk = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sq_sum_feeder_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  sq_sum_feeder #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  function automatic int model_y(input int a, input int b);
    int s;
    s = a * a + b * b;
    return (s > Y_MAX) ? Y_MAX : s;
  endfunction

  function automatic bit model_sat(input int a, input int b);
    return (a * a + b * b) > Y_MAX;
  endfunction

  // Launches one job and records, in edges after acceptance, when the pulse
  // appeared, how many cycles it lasted and when busy dropped.
  task automatic do_job(input int a, input int b, input bit disturb,
                        output int pulse_edge, output int pulse_cnt, output int fall_edge);
    pulse_edge = -1;
    pulse_cnt  = 0;
    fall_edge  = -1;
    @(negedge clk);
    bus.a_bi    = IN_W'(a);
    bus.b_bi    = IN_W'(b);
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (disturb && k == 5) begin
        bus.a_bi    = IN_W'($urandom);
        bus.b_bi    = IN_W'($urandom);
        bus.start_i = 1'b1;
      end
      if (disturb && k == 7) bus.start_i = 1'b0;
      if (bus.sqrt_start_o) begin
        pulse_cnt++;
        if (pulse_edge < 0) pulse_edge = k;
      end
      if (!bus.busy_o) begin
        fall_edge = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i           = 1'b0;
    bus.a_bi        = '0;
    bus.b_bi        = '0;
    bus.start_i     = 1'b0;
    bus.sqrt_busy_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.busy_o, bus.sat_o, bus.sqrt_start_o} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {bus.busy_o, bus.sat_o, bus.sqrt_start_o});
    end
    n_checks++;
    if (bus.y_bo !== '0 || bus.sqrt_x_bo !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got y=%0d x=%0d expected 0 0", bus.y_bo, bus.sqrt_x_bo);
    end
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_job(input string tag, input int a, input int b, input bit disturb);
    int pe, pc, fe, ey;
    bit es;
    ey = model_y(a, b);
    es = model_sat(a, b);
    do_job(a, b, disturb, pe, pc, fe);
    n_checks++;
    if (bus.y_bo !== OUT_W'(ey)) begin
      n_fail++;
      $display("[TB] FAIL %s_y a=%0d b=%0d: got %0d expected %0d", tag, a, b, bus.y_bo, ey);
    end
    n_checks++;
    if (bus.sat_o !== es) begin
      n_fail++;
      $display("[TB] FAIL %s_sat a=%0d b=%0d: got %b expected %b", tag, a, b, bus.sat_o, es);
    end
    n_checks++;
    if (bus.sqrt_x_bo !== OUT_W'(ey)) begin
      n_fail++;
      $display("[TB] FAIL %s_x a=%0d b=%0d: got %0d expected %0d", tag, a, b, bus.sqrt_x_bo, ey);
    end
    n_checks++;
    if (pe != PULSE_AT || pc != 1) begin
      n_fail++;
      $display("[TB] FAIL %s_pulse a=%0d b=%0d: got edge %0d len %0d expected edge %0d len 1",
               tag, a, b, pe, pc, PULSE_AT);
    end
    n_checks++;
    if (fe != PULSE_AT + 1) begin
      n_fail++;
      $display("[TB] FAIL %s_busy_fall a=%0d b=%0d: got edge %0d expected %0d", tag, a, b, fe, PULSE_AT + 1);
    end
  endtask

  task automatic test_directed();
    int va[5] = '{3, 11, 12, 15, 0};
    int vb[5] = '{4, 11, 12, 15, 0};
    for (int i = 0; i < 5; i++) test_job("directed", va[i], vb[i], 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      test_job("random", int'($urandom_range(0, (1 << IN_W) - 1)),
               int'($urandom_range(0, (1 << IN_W) - 1)), 1'b0);
    end
  endtask

  task automatic test_start_ignored();
    test_job("ignored", 3, 4, 1'b1);
    test_job("ignored_rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);
  endtask

  task automatic test_sqrt_busy_wait();
    int a, b, ey;
    bit seen_pulse, x_ok, busy_ok;
    a = int'($urandom_range(1, 15));
    b = int'($urandom_range(1, 15));
    ey = model_y(a, b);
    seen_pulse = 1'b0;
    x_ok = 1'b1;
    busy_ok = 1'b1;
    bus.sqrt_busy_i = 1'b1;
    @(negedge clk);
    bus.a_bi = IN_W'(a);
    bus.b_bi = IN_W'(b);
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.sqrt_start_o) seen_pulse = 1'b1;
      if (!bus.busy_o) busy_ok = 1'b0;
      if (k >= PULSE_AT - 1 && bus.sqrt_x_bo !== OUT_W'(ey)) x_ok = 1'b0;
    end
    n_checks++;
    if (seen_pulse || !busy_ok) begin
      n_fail++;
      $display("[TB] FAIL wait_hold: got pulse=%b busy_held=%b expected pulse=0 busy_held=1", seen_pulse, busy_ok);
    end
    n_checks++;
    if (!x_ok) begin
      n_fail++;
      $display("[TB] FAIL wait_x_stable: got x=%0d expected %0d throughout", bus.sqrt_x_bo, ey);
    end
    bus.sqrt_busy_i = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.sqrt_start_o !== 1'b1 || bus.sqrt_x_bo !== OUT_W'(ey)) begin
      n_fail++;
      $display("[TB] FAIL wait_release: got start=%b x=%0d expected 1 %0d", bus.sqrt_start_o, bus.sqrt_x_bo, ey);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.sqrt_start_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wait_end: got start=%b busy=%b expected 0 0", bus.sqrt_start_o, bus.busy_o);
    end
  endtask

  task automatic test_reset_mid_job();
    bit pulse_seen;
    pulse_seen = 1'b0;
    test_job("pre_reset", 15, 15, 1'b0);
    @(negedge clk);
    bus.a_bi = IN_W'(5);
    bus.b_bi = IN_W'(7);
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy_o, bus.sat_o, bus.sqrt_start_o} !== 3'b000 || bus.y_bo !== '0 || bus.sqrt_x_bo !== '0) begin
      n_fail++;
      $display("[TB] FAIL midjob_reset: got busy=%b sat=%b start=%b y=%0d x=%0d expected all 0",
               bus.busy_o, bus.sat_o, bus.sqrt_start_o, bus.y_bo, bus.sqrt_x_bo);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.sqrt_start_o) pulse_seen = 1'b1;
    end
    @(negedge clk);
    rst_i = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.sqrt_start_o || bus.busy_o) pulse_seen = 1'b1;
    end
    n_checks++;
    if (pulse_seen) begin
      n_fail++;
      $display("[TB] FAIL midjob_no_pulse: got activity=1 expected 0");
    end
    test_job("post_reset", 3, 4, 1'b0);
  endtask

  task automatic test_back_to_back();
    int a1, b1, a2, b2, p1, p2;
    logic [OUT_W-1:0] x1, x2;
    bit low11, high12;
    a1 = int'($urandom_range(0, 15));
    b1 = int'($urandom_range(0, 15));
    a2 = int'($urandom_range(0, 15));
    b2 = int'($urandom_range(0, 15));
    p1 = -1;
    p2 = -1;
    x1 = '0;
    x2 = '0;
    low11 = 1'b0;
    high12 = 1'b0;
    @(negedge clk);
    bus.a_bi = IN_W'(a1);
    bus.b_bi = IN_W'(b1);
    bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.a_bi = IN_W'(a2);
    bus.b_bi = IN_W'(b2);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.sqrt_start_o) begin
        if (p1 < 0) begin p1 = k; x1 = bus.sqrt_x_bo; end
        else if (p2 < 0) begin p2 = k; x2 = bus.sqrt_x_bo; end
      end
      if (k == PULSE_AT + 1) low11 = !bus.busy_o;
      if (k == PULSE_AT + 2) begin
        high12 = bus.busy_o;
        bus.start_i = 1'b0;
      end
    end
    n_checks++;
    if (p1 != PULSE_AT || x1 !== OUT_W'(model_y(a1, b1))) begin
      n_fail++;
      $display("[TB] FAIL b2b_first: got edge %0d x=%0d expected edge %0d x=%0d", p1, x1, PULSE_AT, model_y(a1, b1));
    end
    n_checks++;
    if (!low11 || !high12) begin
      n_fail++;
      $display("[TB] FAIL b2b_rearm: got idle_gap=%b reaccept=%b expected 1 1", low11, high12);
    end
    n_checks++;
    if (p2 != 2 * PULSE_AT + 2 || x2 !== OUT_W'(model_y(a2, b2))) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: got edge %0d x=%0d expected edge %0d x=%0d",
               p2, x2, 2 * PULSE_AT + 2, model_y(a2, b2));
    end
    n_checks++;
    if (bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_idle: got busy=%b expected 0", bus.busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_sqrt_busy_wait();
    test_reset_mid_job();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
